// File: rtl/mem_bus_if.sv
// mem_bus_if: MEM-stage data-bus master, one load/store -> one Wishbone-classic cycle.
// Ports: clk, rst (sync, active-high); stall[5:0], flush from the pipeline controller;
//   cpu_ce_i/we_i/addr_i/sel_i/data_i request in, cpu_data_o load data out, stallreq out;
//   wb_data_i/ack_i bus inputs, wb_addr_o/data_o/we_o/sel_o/stb_o/cyc_o bus outputs;
//   bus_err_o watchdog abort pulse.
// Optional: define DBUS_TIMEOUT_EN to enable the TIMEOUT_CYCLES bus watchdog.
module mem_bus_if #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq,
    input  logic [31:0] wb_data_i,
    input  logic        wb_ack_i,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        WAIT_STALL
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_rd_buf;
    logic        w_launch;
    logic        w_release;
    logic        w_timeout;
    logic        w_stall_any;

    assign w_stall_any = |stall;

`ifdef DBUS_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] r_to_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (w_launch) begin
            r_to_cnt <= '0;
        end else if (r_state == BUSY && !wb_ack_i) begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end
    end

    // Fires in the TIMEOUT_CYCLES-th BUSY cycle that still has no ack.
    assign w_timeout = (r_state == BUSY) && !flush && !wb_ack_i
                       && (r_to_cnt + 8'd1 == TO_LIMIT);
    assign bus_err_o = w_timeout;
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
    assign w_timeout        = 1'b0;
    assign bus_err_o        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_release   = 1'b0;
        stallreq    = 1'b0;
        cpu_data_o  = '0;
        unique case (r_state)
            IDLE: begin
                stallreq = cpu_ce_i & ~flush;
                if (cpu_ce_i && !flush) begin
                    w_launch    = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                stallreq = ~wb_ack_i & ~flush & ~w_timeout;
                // Same-cycle bypass lets the MEM stage advance on the ack edge.
                if (wb_ack_i && !wb_we_o) begin
                    cpu_data_o = wb_data_i;
                end
                if (flush) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (wb_ack_i) begin
                    w_release   = 1'b1;
                    w_state_nxt = w_stall_any ? WAIT_STALL : IDLE;
                end else if (w_timeout) begin
                    w_release   = 1'b1;
                    w_state_nxt = WAIT_STALL;
                end
            end
            WAIT_STALL: begin
                cpu_data_o = r_rd_buf;
                if (flush || !w_stall_any) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_addr_o <= '0;
            wb_data_o <= '0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= '0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            r_rd_buf  <= '0;
        end else begin
            if (w_launch) begin
                wb_addr_o <= cpu_addr_i;
                wb_data_o <= cpu_data_i;
                wb_we_o   <= cpu_we_i;
                wb_sel_o  <= cpu_sel_i;
                wb_stb_o  <= 1'b1;
                wb_cyc_o  <= 1'b1;
            end else if (w_release) begin
                wb_addr_o <= '0;
                wb_data_o <= '0;
                wb_we_o   <= 1'b0;
                wb_sel_o  <= '0;
                wb_stb_o  <= 1'b0;
                wb_cyc_o  <= 1'b0;
            end
            if (r_state == BUSY) begin
                if (flush) begin
                    r_rd_buf <= '0;
                end else if (wb_ack_i) begin
                    if (!wb_we_o) begin
                        r_rd_buf <= wb_data_i;
                    end
                end else if (w_timeout) begin
                    r_rd_buf <= 32'hDEAD_BEEF;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_if.sv
// tb_mem_bus_if: scoreboard bench for mem_bus_if with a Wishbone memory slave.
// Directed cases first, then randomized loads/stores with random wait states and stalls.
module tb_mem_bus_if;

`ifdef DBUS_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic        cpu_ce_i = 1'b0;
    logic        cpu_we_i = 1'b0;
    logic [31:0] cpu_addr_i = '0;
    logic [3:0]  cpu_sel_i = '0;
    logic [31:0] cpu_data_i = '0;
    logic [31:0] cpu_data_o;
    logic        stallreq;
    logic [31:0] wb_data_i = '0;
    logic        wb_ack_i = 1'b0;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        bus_err_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_bus_if #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .stallreq(stallreq), .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i),
        .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .bus_err_o(bus_err_o)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
        logic [3:0]  s;
    } req_t;

    req_t        q_req[$];
    logic [31:0] q_rd[$];
    logic [31:0] rmem[8];
    logic [31:0] smem[8];
    int          n_tests = 0;
    int          n_fail = 0;
    bit          resp_en = 1'b1;
    bit          force_ack = 1'b0;
    int          fix_wait = -1;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endfunction

    function automatic void bad_event(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event seen, none required", nm);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    // Wishbone slave: random or fixed wait states, 8-word memory.
    initial begin : resp
        int   w;
        bit   act;
        bit   pw;
        req_t pr;
        w = 0; act = 0; pw = 0; pr = '0;
        forever begin
            @(posedge clk); #1;
            if (pw) begin
                smem[pr.a[4:2]] = merge(smem[pr.a[4:2]], pr.d, pr.s);
                pw = 0;
            end
            if (!resp_en || rst) begin
                act = 0;
                wb_ack_i = force_ack;
                wb_data_i = 32'h5555_AAAA;
            end else if (wb_stb_o && wb_cyc_o) begin
                if (!act) begin
                    act = 1;
                    w = (fix_wait >= 0) ? fix_wait : int'($urandom_range(0, 3));
                end
                if (w == 0) begin
                    wb_ack_i = 1'b1;
                    act = 0;
                    if (wb_we_o) begin
                        wb_data_i = $urandom;
                        pw = 1;
                        pr = '{wb_addr_o, wb_data_o, wb_we_o, wb_sel_o};
                    end else begin
                        wb_data_i = smem[wb_addr_o[4:2]];
                    end
                end else begin
                    wb_ack_i = 1'b0;
                    wb_data_i = $urandom;
                    w--;
                end
            end else begin
                act = 0;
                wb_ack_i = 1'b0;
                wb_data_i = $urandom;
            end
        end
    end

    // Monitor: pops expected bus requests and load data as the DUT presents them.
    initial begin : mon
        bit          p_stb;
        req_t        p;
        req_t        er;
        bit          hold;
        bit          hnext;
        logic [31:0] hval;
        p_stb = 0; p = '0; hold = 0; hval = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_stb = 0;
                hold = 0;
            end else begin
                if (wb_stb_o && !p_stb) begin
                    if (q_req.size() == 0) begin
                        bad_event("bus_req_unexpected");
                    end else begin
                        er = q_req.pop_front();
                        chk("wb_addr", wb_addr_o, er.a);
                        chk("wb_data", wb_data_o, er.d);
                        chk("wb_we", 32'(wb_we_o), 32'(er.we));
                        chk("wb_sel", 32'(wb_sel_o), 32'(er.s));
                    end
                end else if (wb_stb_o) begin
                    chk("stable_addr", wb_addr_o, p.a);
                    chk("stable_data", wb_data_o, p.d);
                    chk("stable_we", 32'(wb_we_o), 32'(p.we));
                    chk("stable_sel", 32'(wb_sel_o), 32'(p.s));
                end
                chk("wb_cyc", 32'(wb_cyc_o), 32'(wb_stb_o));
                hnext = 0;
                if (wb_stb_o && !flush) begin
                    if (wb_ack_i) begin
                        chk("stallreq_ack", 32'(stallreq), 0);
                        if (!wb_we_o) begin
                            if (q_rd.size() == 0) begin
                                bad_event("load_unexpected");
                            end else begin
                                hval = q_rd.pop_front();
                                chk("load_data", cpu_data_o, hval);
                                hnext = (stall != 6'd0);
                            end
                        end else begin
                            chk("store_cpu_data", cpu_data_o, 0);
                        end
                    end else if (!bus_err_o) begin
                        chk("stallreq_busy", 32'(stallreq), 1);
                        chk("busy_cpu_data", cpu_data_o, 0);
                    end
                end else if (hold && !flush) begin
                    chk("hold_data", cpu_data_o, hval);
                    chk("stallreq_hold", 32'(stallreq), 0);
                    hnext = (stall != 6'd0);
                end
`ifndef DBUS_TIMEOUT_EN
                chk("bus_err_tied", 32'(bus_err_o), 0);
`endif
                hold = hnext;
                p_stb = wb_stb_o;
                p = '{wb_addr_o, wb_data_o, wb_we_o, wb_sel_o};
            end
        end
    end

    // One pipeline access; returns cycles until the pipeline may advance.
    task automatic xfer(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int mode, output int n);
        bit done;
        int k;
        cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = a;
        cpu_data_i = d; cpu_sel_i = s; stall = '0;
        q_req.push_back('{a, d, we, s});
        if (we) rmem[a[4:2]] = merge(rmem[a[4:2]], d, s);
        else q_rd.push_back(rmem[a[4:2]]);
        n = 0; k = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            n++;
            if (!stallreq && stall == 6'd0) begin
                done = 1;
            end else if (n >= 60) begin
                bad_event("xfer_no_completion");
                done = 1;
            end
            @(posedge clk); #1;
            k++;
            if (done) begin
                cpu_ce_i = 1'b0;
                stall = '0;
            end else if (mode == 1) begin
                stall = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            end else if (mode == 2) begin
                stall = (k <= 3) ? 6'b000011 : 6'd0;
            end
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_stb"}, 32'(wb_stb_o), 0);
        chk({nm, "_cyc"}, 32'(wb_cyc_o), 0);
        chk({nm, "_we"}, 32'(wb_we_o), 0);
        chk({nm, "_sel"}, 32'(wb_sel_o), 0);
        chk({nm, "_addr"}, wb_addr_o, 0);
        chk({nm, "_wdata"}, wb_data_o, 0);
        chk({nm, "_stallreq"}, 32'(stallreq), 0);
        chk({nm, "_cpu_data"}, cpu_data_o, 0);
    endtask

    initial begin : main
        int n;
        for (int i = 0; i < 8; i++) begin
            rmem[i] = $urandom;
            smem[i] = rmem[i];
        end
        rmem[0] = 32'h1234_5678; smem[0] = rmem[0];
        rmem[1] = 32'hA5A5_A5A5; smem[1] = rmem[1];

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_bus_err", 32'(bus_err_o), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        fix_wait = 0;
        xfer(1'b0, 32'h0000_0100, 32'h0, 4'hF, 0, n);
        chk("load0ws_cycles", n, 2);

        fix_wait = 3;
        xfer(1'b1, 32'h0000_0200, 32'hCAFE_F00D, 4'h3, 0, n);
        chk("store3ws_cycles", n, 5);

        fix_wait = 0;
        xfer(1'b0, 32'h0000_0104, 32'h0, 4'hF, 2, n);
        chk("load_stall_cycles", n, 5);

        // Flush in the second BUSY cycle, then a stray ack.
        resp_en = 1'b0;
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0108;
        cpu_data_i = 32'h0; cpu_sel_i = 4'hF;
        q_req.push_back('{32'h0000_0108, 32'h0, 1'b0, 4'hF});
        repeat (2) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_stallreq", 32'(stallreq), 0);
        force_ack = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; cpu_ce_i = 1'b0;
        @(negedge clk);
        chk_idle_outputs("flush");
        force_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk_idle_outputs("late_ack");

        // Reset in the middle of a store.
        @(posedge clk); #1;
        cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h0000_010C;
        cpu_data_i = 32'hFFFF_FFFF; cpu_sel_i = 4'hF;
        q_req.push_back('{32'h0000_010C, 32'hFFFF_FFFF, 1'b1, 4'hF});
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1; cpu_ce_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("mid_reset");
        @(posedge clk); #1;
        resp_en = 1'b1;
        fix_wait = -1;
        xfer(1'b0, 32'h0000_010C, 32'h0, 4'hF, 0, n);

`ifdef DBUS_TIMEOUT_EN
        resp_en = 1'b0;
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0110;
        cpu_data_i = 32'h0; cpu_sel_i = 4'hF;
        q_req.push_back('{32'h0000_0110, 32'h0, 1'b0, 4'hF});
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("to_bus_err", 32'(bus_err_o), (k == 4) ? 1 : 0);
            chk("to_stallreq", 32'(stallreq), (k == 4) ? 0 : 1);
        end
        @(posedge clk); #1;
        cpu_ce_i = 1'b0;
        @(negedge clk);
        chk("to_cpu_data", cpu_data_o, 32'hDEAD_BEEF);
        chk("to_stb", 32'(wb_stb_o), 0);
        chk("to_bus_err_pulse", 32'(bus_err_o), 0);
        @(posedge clk); #1;
        resp_en = 1'b1;
`endif

        for (int t = 0; t < 150; t++) begin
            logic [31:0] a;
            logic [3:0]  s;
            bit          we;
            a  = 32'h0000_0300 | (32'($urandom_range(0, 7)) << 2);
            s  = 4'($urandom_range(1, 15));
            we = 1'($urandom_range(0, 1));
            xfer(we, a, $urandom, s, 1, n);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("req_queue_empty", q_req.size(), 0);
        chk("load_queue_empty", q_rd.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_bus_if.md
Name: mem_bus_if

Overview:
- Data-side bus master for the MEM stage. It turns the MEM stage's single-cycle load/store request into a Wishbone-classic transaction.
- While the bus is busy it raises a stall request to the pipeline controller, so the MEM/WB register is not loaded until the read data or write acknowledge exists.
- It sits between the MEM stage and the external data bus. Load data comes back to the MEM stage, which forwards it into MEM/WB.

Parameters:
- TIMEOUT_CYCLES, 255: bus-watchdog limit in cycles. Used only when DBUS_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset (`RstEnable` = 1)
- stall  in  6  pipeline stall vector from the controller; bit 0 = PC … bit 5 = WB
- flush  in  1  pipeline flush (exception); aborts the outstanding access
- cpu_ce_i  in  1  MEM-stage memory access request
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address
- cpu_sel_i  in  4  byte-lane select
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data returned to the MEM stage
- stallreq  out  1  MEM-stage stall request to the controller
- wb_data_i  in  32  bus read data
- wb_ack_i  in  1  bus acknowledge
- wb_addr_o  out  32  bus address
- wb_data_o  out  32  bus write data
- wb_we_o  out  1  bus write enable
- wb_sel_o  out  4  bus byte select
- wb_stb_o  out  1  bus strobe
- wb_cyc_o  out  1  bus cycle
- bus_err_o  out  1  watchdog abort flag; DBUS_TIMEOUT_EN only, otherwise tied 0

Behaviour:
- FSM states: IDLE, BUSY, WAIT_STALL.
- Registered wb_* outputs and rd_buf (32-bit) all reset to 0. FSM resets to IDLE. Reset overrides everything, including mid-transaction; the bus is simply released.
- IDLE:
  - If cpu_ce_i=1 and flush=0: on the next edge load wb_addr_o, wb_data_o, wb_we_o and wb_sel_o from the cpu_* inputs, set wb_stb_o=wb_cyc_o=1, and go to BUSY.
  - Otherwise hold and keep all wb_* at 0.
- BUSY, wb_ack_i=1:
  - On the edge, clear all wb_* to 0.
  - If the access was a load (wb_we_o=0), rd_buf <= wb_data_i.
  - Next state is WAIT_STALL if stall != 6'b0, else IDLE.
- BUSY, wb_ack_i=0: hold all bus outputs stable; stb, cyc and address must not change until ack.
- BUSY, flush=1 (priority over ack): clear all wb_* to 0, rd_buf <= 0, go to IDLE.
- WAIT_STALL:
  - Covers the case where some other stage is still stalling after our transaction finished.
  - Hold rd_buf. Go to IDLE on the first cycle with stall == 6'b0.
  - flush=1 forces IDLE.
- stallreq (combinational):
  - IDLE: cpu_ce_i & ~flush.
  - BUSY: ~wb_ack_i & ~flush.
  - WAIT_STALL: 0.
- cpu_data_o (combinational):
  - IDLE: 0.
  - BUSY: wb_data_i when wb_ack_i=1 and wb_we_o=0 (same-cycle bypass), else 0.
  - WAIT_STALL: rd_buf.
- Minimum latency: request in cycle N, stb high from N+1. Zero-wait-state ack in N+1 releases the stall in N+1, so the pipeline stalls exactly one extra cycle.
- A new request is accepted only in IDLE; back-to-back accesses cost at least 2 cycles each.
- cpu_ce_i is not sampled in BUSY or WAIT_STALL (the pipeline is frozen).

Optional Feature:
- Macro: DBUS_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - On reaching TIMEOUT_CYCLES it aborts exactly like flush, except it goes to WAIT_STALL with rd_buf=32'hDEADBEEF.
  - It also pulses bus_err_o=1 for one cycle.
  - stallreq drops in that same cycle.
- Undefined: no counter; BUSY waits indefinitely; bus_err_o is constant 0.

Test Plan:
- Load with ack one cycle after stb: cpu_ce_i=1, we=0, addr=32'h0000_0100, sel=4'hF, wb_data_i=32'h1234_5678, stall=0 → stb/cyc high one cycle; cpu_data_o=32'h1234_5678 in the ack cycle; stallreq high 1 cycle then 0; FSM back in IDLE.
- Store with 3 wait states: we=1, addr=32'h0000_0200, data=32'hCAFE_F00D, sel=4'h3 → wb_* stable for 4 cycles; stallreq=1 until the ack cycle; wb_we_o=0 after ack; cpu_data_o=0 throughout.
- Load ack while stall=6'b000011 held 2 more cycles, wb_data_i=32'hA5A5_A5A5 → WAIT_STALL, cpu_data_o=32'hA5A5_A5A5 and stallreq=0 for those cycles; IDLE when stall=0.
- flush=1 in the second BUSY cycle, no ack → all wb_* 0 next cycle, IDLE, stallreq=0; a later ack is ignored.
- rst=1 asserted during BUSY → all outputs 0 on the next edge, IDLE; a new request after reset completes normally.
- DBUS_TIMEOUT_EN with TIMEOUT_CYCLES=4, ack never given → abort after 4 BUSY cycles; bus_err_o one-cycle pulse; cpu_data_o=32'hDEADBEEF; stb=0.
